// File: rtl/simd_rf_pkg.sv
// rtl/simd_rf_pkg.sv - shared types, default sizes and lane helper for the multi-lane register file
package simd_rf_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_e;

   localparam int unsigned DEF_DATA_W   = 16;
   localparam int unsigned DEF_LANES    = 4;
   localparam int unsigned DEF_NUM_REGS = 32;

   // Low bit position of a lane inside a packed vector register
   function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned data_w);
      return lane * data_w;
   endfunction

endpackage

// File: rtl/simd_rf_scoreboard.sv
// rtl/simd_rf_scoreboard.sv - one pending-write bit per register with set/clear ports and two read taps
module simd_rf_scoreboard
   import simd_rf_pkg::*;
#(
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned AW       = $clog2(NUM_REGS)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_all_i,
   input  logic          set_en_i,
   input  logic [AW-1:0] set_idx_i,
   input  logic          clr_en_i,
   input  logic [AW-1:0] clr_idx_i,
   input  logic [AW-1:0] tap_a_idx_i,
   input  logic [AW-1:0] tap_b_idx_i,
   output logic          tap_a_o,
   output logic          tap_b_o
);

   logic [NUM_REGS-1:0] sb_q;
   logic [NUM_REGS-1:0] sb_d;

   // Set is applied after clear so a same-cycle reserve wins over a completing write
   always_comb begin
      sb_d = sb_q;
      if (clr_en_i) sb_d[clr_idx_i] = 1'b0;
      if (set_en_i) sb_d[set_idx_i] = 1'b1;
      if (clr_all_i) sb_d = '0;
   end

   // Pending bits are the only state here that needs a reset value
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sb_q <= '0;
      else         sb_q <= sb_d;
   end

   assign tap_a_o = sb_q[tap_a_idx_i];
   assign tap_b_o = sb_q[tap_b_idx_i];

endmodule

// File: rtl/simd_regfile_mlane.sv
// rtl/simd_regfile_mlane.sv - multi-lane vector register file with lane-masked writes, bypass and clear sequencer
module simd_regfile_mlane
   import simd_rf_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned LANES    = DEF_LANES,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   localparam int unsigned VW      = LANES * DATA_W,
   localparam int unsigned AW      = $clog2(NUM_REGS)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_req_i,
   output logic             ready_o,
   input  logic [AW-1:0]    rs1_i,
   input  logic [AW-1:0]    rs2_i,
   input  logic             rs1_rd_en_i,
   input  logic             rs2_rd_en_i,
   output logic [VW-1:0]    rs1_data_o,
   output logic [VW-1:0]    rs2_data_o,
   output logic             rs1_busy_o,
   output logic             rs2_busy_o,
   input  logic [AW-1:0]    rd_i,
   input  logic             rd_wr_en_i,
   input  logic [LANES-1:0] wr_lane_mask_i,
   input  logic [VW-1:0]    wr_data_i,
   input  logic             rsv_en_i,
   input  logic [AW-1:0]    rsv_rd_i
);

   rf_state_e     state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;

   // Array is deliberately left without reset; the clear sequencer zeroes it instead
   logic [VW-1:0] mem_q [NUM_REGS];

   logic          ready;
   logic          wr_ok;
   logic          rsv_ok;
   logic [VW-1:0] wr_bitmask;
   logic [VW-1:0] wr_merged;
   logic          mem_we;
   logic [AW-1:0] mem_widx;
   logic [VW-1:0] mem_wdata;
   logic          sb_a, sb_b;

   assign ready   = (state_q == READY);
   assign ready_o = ready;

   // A clear request takes priority over any write or reserve in the same cycle
   assign wr_ok  = ready & rd_wr_en_i & (rd_i != '0) & ~clr_req_i;
   assign rsv_ok = ready & rsv_en_i & (rsv_rd_i != '0) & ~clr_req_i;

   // Expand the per-lane mask into a per-bit mask
   always_comb begin
      wr_bitmask = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         wr_bitmask[lane_lo(i, DATA_W) +: DATA_W] = {DATA_W{wr_lane_mask_i[i]}};
      end
   end

   // Stored value with masked lanes replaced; used both for the write and for bypass
   assign wr_merged = (mem_q[rd_i] & ~wr_bitmask) | (wr_data_i & wr_bitmask);

   // Clear FSM: walk idx from 1 to NUM_REGS-1, or restart on a clear request
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         CLEAR: begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(NUM_REGS - 1)) state_d = READY;
         end
         READY: begin
            if (clr_req_i) begin
               state_d = CLEAR;
               idx_d   = AW'(1);
            end
         end
         default: begin
            state_d = CLEAR;
            idx_d   = AW'(1);
         end
      endcase
   end

   // FSM state and clear index registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= CLEAR;
         idx_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Single array write port shared by the clear walk and normal writes
   always_comb begin
      mem_we    = wr_ok;
      mem_widx  = rd_i;
      mem_wdata = wr_merged;
      if (state_q == CLEAR) begin
         mem_we    = 1'b1;
         mem_widx  = idx_q;
         mem_wdata = '0;
      end
   end

   // Array storage update
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[mem_widx] <= mem_wdata;
   end

   // Read ports: zero when disabled, addressing r0 or not ready; bypass a same-cycle write
   assign rs1_data_o = (rs1_rd_en_i && ready && (rs1_i != '0))
                     ? ((wr_ok && (rd_i == rs1_i)) ? wr_merged : mem_q[rs1_i]) : '0;
   assign rs2_data_o = (rs2_rd_en_i && ready && (rs2_i != '0))
                     ? ((wr_ok && (rd_i == rs2_i)) ? wr_merged : mem_q[rs2_i]) : '0;

   simd_rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_sb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clr_all_i   (ready & clr_req_i),
      .set_en_i    (rsv_ok),
      .set_idx_i   (rsv_rd_i),
      .clr_en_i    (wr_ok),
      .clr_idx_i   (rd_i),
      .tap_a_idx_i (rs1_i),
      .tap_b_idx_i (rs2_i),
      .tap_a_o     (sb_a),
      .tap_b_o     (sb_b)
   );

   // Busy reflects only the registered scoreboard bit
   assign rs1_busy_o = sb_a & rs1_rd_en_i & (rs1_i != '0);
   assign rs2_busy_o = sb_b & rs2_rd_en_i & (rs2_i != '0);

endmodule

// File: tb/tb_simd_regfile_mlane.sv
// tb/tb_simd_regfile_mlane.sv - directed scoreboard bench for the multi-lane register file
module tb_simd_regfile_mlane;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr_req;
   logic        ready;
   logic [4:0]  rs1, rs2;
   logic        rs1_en, rs2_en;
   logic [63:0] rs1_data, rs2_data;
   logic        rs1_busy, rs2_busy;
   logic [4:0]  rd;
   logic        wr_en;
   logic [3:0]  mask;
   logic [63:0] wdata;
   logic        rsv_en;
   logic [4:0]  rsv_rd;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cnt;

   simd_regfile_mlane dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clr_req_i      (clr_req),
      .ready_o        (ready),
      .rs1_i          (rs1),
      .rs2_i          (rs2),
      .rs1_rd_en_i    (rs1_en),
      .rs2_rd_en_i    (rs2_en),
      .rs1_data_o     (rs1_data),
      .rs2_data_o     (rs2_data),
      .rs1_busy_o     (rs1_busy),
      .rs2_busy_o     (rs2_busy),
      .rd_i           (rd),
      .rd_wr_en_i     (wr_en),
      .wr_lane_mask_i (mask),
      .wr_data_i      (wdata),
      .rsv_en_i       (rsv_en),
      .rsv_rd_i       (rsv_rd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic chk(input logic [63:0] obs);
      exp_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL queue_empty observed=%h expected=none", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic wait_ready(output int c);
      c = 0;
      while (!ready && c < 100) begin
         tick();
         c++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clr_req = 1'b0; rs1 = '0; rs2 = '0; rs1_en = 1'b0; rs2_en = 1'b0;
      rd = '0; wr_en = 1'b0; mask = '0; wdata = '0; rsv_en = 1'b0; rsv_rd = '0;
      repeat (3) tick();

      // Reset state
      rs1 = 5'd5; rs1_en = 1'b1; #1;
      push("rst_ready", 64'd0);    chk(64'(ready));
      push("rst_rs1_data", 64'd0); chk(rs1_data);
      push("rst_rs1_busy", 64'd0); chk(64'(rs1_busy));

      // Initial clear latency
      rst_n = 1'b1;
      push("init_clear_edges", 64'd31);
      wait_ready(cnt);
      chk(64'(cnt));
      #1;
      push("r5_after_init", 64'd0); chk(rs1_data);

      // Full write then masked write with bypass
      rd = 5'd3; wr_en = 1'b1; mask = 4'b1111; wdata = 64'h4444_3333_2222_1111;
      tick();
      mask = 4'b0101; wdata = 64'hDDDD_CCCC_BBBB_AAAA; rs1 = 5'd3; #1;
      push("r3_bypass", 64'h4444_CCCC_2222_AAAA); chk(rs1_data);
      tick();
      wr_en = 1'b0; #1;
      push("r3_stored", 64'h4444_CCCC_2222_AAAA); chk(rs1_data);

      // Register 0 is hardwired
      rd = 5'd0; wr_en = 1'b1; mask = 4'b1111; wdata = '1; rsv_en = 1'b1; rsv_rd = 5'd0; rs1 = 5'd0; #1;
      push("r0_bypass", 64'd0); chk(rs1_data);
      tick();
      wr_en = 1'b0; rsv_en = 1'b0; #1;
      push("r0_read", 64'd0); chk(rs1_data);
      push("r0_busy", 64'd0); chk(64'(rs1_busy));

      // Reserve and write interaction on r7
      rsv_en = 1'b1; rsv_rd = 5'd7; rs1 = 5'd7; #1;
      push("r7_busy_no_bypass", 64'd0); chk(64'(rs1_busy));
      tick();
      rsv_en = 1'b0; #1;
      push("r7_busy_set", 64'd1); chk(64'(rs1_busy));
      rd = 5'd7; wr_en = 1'b1; mask = 4'b1111; wdata = 64'h0123_4567_89AB_CDEF; rsv_en = 1'b1;
      tick();
      wr_en = 1'b0; rsv_en = 1'b0; #1;
      push("r7_busy_rsv_wins", 64'd1); chk(64'(rs1_busy));
      push("r7_data", 64'h0123_4567_89AB_CDEF); chk(rs1_data);
      wr_en = 1'b1; mask = 4'b1000; wdata = 64'h1111_2222_3333_4444; #1;
      push("r7_busy_during_write", 64'd1); chk(64'(rs1_busy));
      tick();
      wr_en = 1'b0; #1;
      push("r7_busy_cleared", 64'd0); chk(64'(rs1_busy));
      push("r7_lane3_write", 64'h1111_4567_89AB_CDEF); chk(rs1_data);

      // Zero-mask write leaves data but still clears busy
      rsv_en = 1'b1; tick(); rsv_en = 1'b0;
      wr_en = 1'b1; mask = 4'b0000; wdata = '1; #1;
      push("r7_zero_mask_bypass", 64'h1111_4567_89AB_CDEF); chk(rs1_data);
      tick();
      wr_en = 1'b0; #1;
      push("r7_zero_mask_busy", 64'd0); chk(64'(rs1_busy));
      push("r7_zero_mask_data", 64'h1111_4567_89AB_CDEF); chk(rs1_data);

      // Second read port, enabled and disabled
      rsv_en = 1'b1; rsv_rd = 5'd3; tick(); rsv_en = 1'b0;
      rs2 = 5'd3; rs2_en = 1'b0; #1;
      push("rs2_off_data", 64'd0); chk(rs2_data);
      push("rs2_off_busy", 64'd0); chk(64'(rs2_busy));
      rs2_en = 1'b1; #1;
      push("rs2_on_data", 64'h4444_CCCC_2222_AAAA); chk(rs2_data);
      push("rs2_on_busy", 64'd1); chk(64'(rs2_busy));

      // Clear request drops the same-cycle write; writes during clear are ignored
      rsv_en = 1'b1; rsv_rd = 5'd9; tick();
      clr_req = 1'b1; rd = 5'd9; wr_en = 1'b1; mask = 4'b1111; wdata = 64'd1; rsv_rd = 5'd10;
      tick();
      clr_req = 1'b0; rd = 5'd4; wdata = 64'hFFFF; rsv_rd = 5'd4;
      push("clr_ready_low", 64'd0); chk(64'(ready));
      push("clr_edges", 64'd31);
      wait_ready(cnt);
      wr_en = 1'b0; rsv_en = 1'b0;
      chk(64'(cnt));
      rs1 = 5'd9; rs2 = 5'd4; #1;
      push("r9_after_clr", 64'd0);    chk(rs1_data);
      push("r9_busy_after_clr", 64'd0); chk(64'(rs1_busy));
      push("r4_write_in_clear", 64'd0); chk(rs2_data);
      push("r4_rsv_in_clear", 64'd0); chk(64'(rs2_busy));
      rs1 = 5'd3; rs2 = 5'd7; #1;
      push("r3_after_clr", 64'd0);    chk(rs1_data);
      push("r7_busy_after_clr", 64'd0); chk(64'(rs2_busy));

      // Reset in the middle of a clear restarts the full walk
      rd = 5'd3; wr_en = 1'b1; mask = 4'b1111; wdata = 64'hABCD; tick(); wr_en = 1'b0;
      clr_req = 1'b1; tick(); clr_req = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0; #1;
      push("ready_in_reset", 64'd0); chk(64'(ready));
      tick();
      rst_n = 1'b1;
      push("restart_edges", 64'd31);
      wait_ready(cnt);
      chk(64'(cnt));
      #1;
      push("r3_after_restart", 64'd0); chk(rs1_data);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/simd_regfile_mlane.md
# simd_regfile_mlane

Parametrised multi-lane register file for the SIMD datapath, successor to the single-lane 16-bit register file. Holds NUM_REGS vector registers of LANES × DATA_W bits, with per-lane write masking, write-to-read bypass, a hardware clear sequencer (the array is not reset-cleared), and a one-bit-per-register pending-write scoreboard used by issue logic to stall on RAW hazards. Sits between decode/issue and the SIMD ALU lanes.

## Interface
- DATA_W, 16, bits per lane
- LANES, 4, lanes per register; vector width VW = LANES*DATA_W
- NUM_REGS, 32, register count (power of two, ≥4); AW = $clog2(NUM_REGS)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr_req  in  1  request a full array clear (pulse, sampled while ready=1)
- ready  out  1  1 = array valid, reads/writes/reserves accepted
- rs1, rs2  in  AW  read addresses
- rs1_rd_en, rs2_rd_en  in  1  read enables
- rs1_data, rs2_data  out  VW  read data, lane i = bits [i*DATA_W +: DATA_W]
- rs1_busy, rs2_busy  out  1  scoreboard bit of addressed register
- rd  in  AW  write address
- rd_wr_en  in  1  write enable
- wr_lane_mask  in  LANES  per-lane write enable
- wr_data  in  VW  write data
- rsv_en  in  1  mark register rsv_rd as pending-write
- rsv_rd  in  AW  register to reserve

## Operation
- States: CLEAR, READY. rst_n low → CLEAR, clear index = 1, scoreboard all 0.
- CLEAR: each cycle writes 0 to entry[idx] (all lanes), idx++. After idx = NUM_REGS-1 is written → READY. Writes, reserves, clr_req ignored in CLEAR.
- READY + clr_req=1 → CLEAR next edge, idx=1, scoreboard cleared; rd_wr_en/rsv_en in the same cycle are dropped.
- Write (READY, rd_wr_en, rd≠0): at edge, entry[rd] lane i ← wr_data lane i for each i with wr_lane_mask[i]=1; unmasked lanes keep old value. Clears sb[rd]. rd=0 ignored; mask all-zero = no data change, sb[rd] still cleared.
- Reserve (READY, rsv_en, rsv_rd≠0): sb[rsv_rd] ← 1 at edge. Reserve and write to same register in same cycle: data written, sb ends 1 (reserve wins).
- Read (combinational): rsX_data = 0 if rsX_rd_en=0, rsX=0, or ready=0. Otherwise stored entry, with bypass: if rd_wr_en & rd=rsX & rd≠0 & ready & ~clr_req, lanes with wr_lane_mask=1 show wr_data, others stored value.
- rsX_busy = sb[rsX] & rsX_rd_en & (rsX≠0); registered value only (no bypass of same-cycle write/reserve).
- Entry 0 is never written; reads always 0.

## Timing
- Reset: ready=0, rs1_data=rs2_data=0, rs1_busy=rs2_busy=0, state CLEAR, asynchronously on rst_n fall.
- Clear latency: NUM_REGS-1 cycles from reset release (or from clr_req edge) to ready=1; with NUM_REGS=32, ready rises on the 31st rising edge after release.
- Write visible at read port the same cycle (bypass) and from the stored array from the next cycle.
- Reserve visible on busy the cycle after the edge; write clears busy the cycle after the edge.
- rst_n asserted mid-clear or mid-write: restart CLEAR from idx 1; partially written data undefined until clear completes.

## Structure
- Package simd_rf_pkg: state enum {CLEAR, READY}, default DATA_W/LANES/NUM_REGS constants, lane-slice helper function.
- Sub-module simd_rf_scoreboard: NUM_REGS-bit flop vector with async reset, set/clear ports, sync clear-all, two read taps.
- Top holds the array (no reset on array), clear FSM, lane-mask write, bypass muxes.

## Test plan
- Reset release, NUM_REGS=32 → ready low 30 cycles, high on cycle 31; read r5 with rd_en → 0.
- Write r3 = 64'h4444_3333_2222_1111 mask 4'b1111, next cycle write r3 = 64'hDDDD_CCCC_BBBB_AAAA mask 4'b0101 → read r3 = 64'h4444_CCCC_2222_AAAA; same-cycle read during second write shows that value via bypass.
- Write r0 = all-ones; read rs1=0 with rd_en=1 → 0; rsv_rd=0 → rs1_busy stays 0.
- Reserve r7 → busy=1 next cycle; write r7 with reserve r7 same cycle → busy stays 1; plain write r7 → busy=0 next cycle.
- rs2_rd_en=0 on r3 holding nonzero data → rs2_data=0, rs2_busy=0.
- clr_req with simultaneous write r9=1 → write dropped, ready low 31 cycles, r9 and all busy read 0 afterwards; rst_n pulse mid-clear → clear restarts, full 31 cycles.
